led_display_arbiter: RTL and testbench
======================================

// Module: led_display_arbiter
// PURPOSE
//  Shares one LED bank between NUM_REQ requesters (status codes, frame index, error flags).
//  Round-robin arbitration with a minimum hold time, so each pattern stays readable.
//  With no active requester, a free-running heartbeat counter is shown.
//  Sits between the user status sources and the board LED pins.
// PARAMETERS
//  LED_WIDTH   8          LED bank width
//  NUM_REQ     4          requester count (>=2)
//  TICK_DIV    24'hFF_FFFF  clk cycles per display tick (~0.3 s at 50 MHz); >=2
//  HOLD_TICKS  4          minimum ticks a grant is held before it may rotate; >=1
// PORTS
//  clk        in   1                  system clock
//  rst        in   1                  asynchronous, active-high reset
//  req        in   NUM_REQ            request level, one bit per requester
//  req_data   in   NUM_REQ*LED_WIDTH  patterns; requester i at [i*LED_WIDTH +: LED_WIDTH]
//  req_blink  in   NUM_REQ            blink request (present only with LED_BLINK_EN)
//  grant      out  NUM_REQ            one-hot owner, 0 when idle
//  busy       out  1                  1 while any grant is held
//  led_data   out  LED_WIDTH          registered LED drive
// BEHAVIOUR
//  - Reset: grant=0, busy=0, led_data=0, state=IDLE, rr_ptr=0, idle_cnt=0, tick_cnt=0,
//    hold_cnt=0, blink_phase=0. All outputs are registered.
//  - Tick: tick_cnt counts 0..TICK_DIV-1 and wraps. tick=1 for one cycle when tick_cnt==TICK_DIV-1.
//  - Arbitration: round-robin, searching upward from rr_ptr and wrapping at NUM_REQ-1.
//    On each grant, rr_ptr <= winner+1 (mod NUM_REQ).
//  - IDLE: idle_cnt increments on each tick and wraps at 2^LED_WIDTH-1 -> 0. led_data <= idle_cnt.
//    If any req is high, the next edge moves to OWN, sets grant/busy, clears hold_cnt, and loads
//    led_data from the winner's req_data. Latency is 1 cycle.
//  - OWN: led_data <= req_data[owner] every cycle, so pattern changes show with 1 cycle of latency.
//    hold_cnt increments on tick and saturates at HOLD_TICKS. idle_cnt is frozen.
//  - Rotation: when hold_cnt==HOLD_TICKS and another requester is high, the next edge grants the
//    round-robin winner directly (OWN->OWN, no idle gap) and clears hold_cnt.
//    If only the owner is requesting, the grant is kept indefinitely.
//  - Owner release: the owner's req low in OWN -> next edge goes to IDLE with grant=0 and busy=0,
//    even if others are pending. Arbitration resumes one cycle later.
//    In IDLE, led_data resumes the retained idle_cnt.
//  - Simultaneous events: a grant/rotation in the same cycle as a tick clears hold_cnt
//    (the tick is not counted). An owner release beats rotation.
//  - Reset mid-grant: all state returns to reset values immediately.
//    Requests still pending are re-arbitrated from rr_ptr=0.
// CONFIGURATION
//  LED_BLINK_EN defined:
//   - adds port req_blink. blink_phase toggles on each tick in OWN and clears on every grant change.
//   - If req_blink[owner]=1 and blink_phase=1, led_data <= 0.
//  LED_BLINK_EN undefined:
//   - req_blink and blink_phase are absent; the owner's pattern is shown steadily.
// STRUCTURE
//  - Package led_disp_pkg: state enum {IDLE, OWN}; default parameter constants
//    (DEF_TICK_DIV, DEF_HOLD_TICKS); the one-hot-to-index function.
//  - Sub-module led_tick_gen (TICK_DIV): prescaler with a one-cycle tick output.
//  - Arbiter FSM, hold counter and LED output register stay in this module.
// TESTING  (TICK_DIV=4, HOLD_TICKS=2, NUM_REQ=4, LED_WIDTH=8)
//  1. No req for 20 cycles after reset -> grant=0; led_data steps 0,1,2,3,4 at one step per 4 cycles.
//  2. req[2]=1 with data 8'hA5 at cycle n -> grant=4'b0100, busy=1, led_data=8'hA5 at n+1.
//     Data changed to 8'h3C -> led_data=8'h3C one cycle later.
//  3. req[1] and req[3] held high -> grant=4'b0010 first. After 2 ticks it switches to 4'b1000 with
//     no zero cycle, then back to 4'b0010 after 2 more ticks.
//  4. Owner req[1] dropped after 1 tick while req[3] is pending -> grant=0 for one cycle,
//     led_data = retained idle_cnt, then grant=4'b1000.
//  5. rst pulsed mid-grant, asynchronous to clk -> grant, busy and led_data go to 0 before the next edge.
//     After release, req[0] and req[2] pending -> grant=4'b0001.
//  6. LED_BLINK_EN, req_blink[2]=1, req[2] data 8'hFF -> led_data alternates 8'hFF/8'h00 every 4 cycles.
//     Without the macro, it holds 8'hFF.

Source files
------------

// File: rtl/led_disp_pkg.sv
// rtl/led_disp_pkg.sv - shared types, defaults and helpers for the LED display arbiter
// Optional feature macro used by the bundle: LED_BLINK_EN
package led_disp_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } disp_state_e;

    localparam int DEF_TICK_DIV   = 24'hFF_FFFF;
    localparam int DEF_HOLD_TICKS = 4;

    // Index of the set bit of a one-hot vector; supports up to 32 requesters.
    function automatic logic [4:0] oh_to_idx(input logic [31:0] oh);
        logic [4:0] idx;
        idx = '0;
        for (int i = 0; i < 32; i++) begin
            if (oh[i]) begin
                idx = 5'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/led_display_arbiter_tick_gen.sv
// rtl/led_display_arbiter_tick_gen.sv - display tick prescaler, one-cycle pulse every TICK_DIV clocks
module led_tick_gen #(
    parameter int TICK_DIV = 24'hFF_FFFF
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int CNT_W = $clog2(TICK_DIV);

    logic [CNT_W-1:0] tick_cnt_q;
    logic [CNT_W-1:0] tick_cnt_d;

    assign tick = (tick_cnt_q == CNT_W'(TICK_DIV - 1));

    always_comb begin
        tick_cnt_d = tick ? '0 : tick_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_cnt_q <= '0;
        end else begin
            tick_cnt_q <= tick_cnt_d;
        end
    end

endmodule

// File: rtl/led_display_arbiter.sv
// rtl/led_display_arbiter.sv - round-robin LED bank sharing with minimum hold and idle heartbeat
// LED_BLINK_EN adds req_blink and a tick-rate blanking phase for the current owner.
module led_display_arbiter
    import led_disp_pkg::*;
#(
    parameter int LED_WIDTH  = 8,
    parameter int NUM_REQ    = 4,
    parameter int TICK_DIV   = DEF_TICK_DIV,
    parameter int HOLD_TICKS = DEF_HOLD_TICKS
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_REQ-1:0]             req,
    input  logic [NUM_REQ*LED_WIDTH-1:0]   req_data,
`ifdef LED_BLINK_EN
    input  logic [NUM_REQ-1:0]             req_blink,
`endif
    output logic [NUM_REQ-1:0]             grant,
    output logic                           busy,
    output logic [LED_WIDTH-1:0]           led_data
);

    localparam int IDX_W  = $clog2(NUM_REQ);
    localparam int HOLD_W = $clog2(HOLD_TICKS + 1);

    disp_state_e          state_q, state_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;
    logic                 busy_q, busy_d;
    logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [LED_WIDTH-1:0] idle_cnt_q, idle_cnt_d;
    logic [HOLD_W-1:0]    hold_cnt_q, hold_cnt_d;
    logic [LED_WIDTH-1:0] led_q, led_d;

    logic                 tick;
    logic                 found;
    logic [IDX_W-1:0]     win_idx;
    logic [IDX_W-1:0]     cand_idx;
    logic [IDX_W-1:0]     rr_next;
    logic [NUM_REQ-1:0]   win_oh;
    logic [IDX_W-1:0]     owner_idx;
    logic                 owner_req;
    logic                 hold_full;
    logic                 blank;
    logic [LED_WIDTH-1:0] win_data;
    logic [LED_WIDTH-1:0] owner_data;
    int                   cand;

    led_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    // Round-robin search: first requester at or above rr_ptr, wrapping.
    // The owner sits last in the order, so any other requester wins first.
    always_comb begin
        found    = 1'b0;
        win_idx  = '0;
        cand     = 0;
        cand_idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = int'(rr_ptr_q) + k;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            cand_idx = IDX_W'(cand);
            if (!found && req[cand_idx]) begin
                found   = 1'b1;
                win_idx = cand_idx;
            end
        end
    end

    always_comb begin
        win_oh          = '0;
        win_oh[win_idx] = 1'b1;
        rr_next         = (win_idx == IDX_W'(NUM_REQ - 1)) ? '0 : win_idx + IDX_W'(1);
    end

    assign owner_idx  = IDX_W'(oh_to_idx(32'(grant_q)));
    assign owner_req  = |(req & grant_q);
    assign hold_full  = (hold_cnt_q == HOLD_W'(HOLD_TICKS));
    assign win_data   = req_data[win_idx*LED_WIDTH +: LED_WIDTH];
    assign owner_data = req_data[owner_idx*LED_WIDTH +: LED_WIDTH];

`ifdef LED_BLINK_EN
    logic blink_phase_q, blink_phase_d;
    assign blank = req_blink[owner_idx] && blink_phase_q;
`else
    assign blank = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        busy_d     = busy_q;
        rr_ptr_d   = rr_ptr_q;
        idle_cnt_d = idle_cnt_q;
        hold_cnt_d = hold_cnt_q;
        led_d      = led_q;
`ifdef LED_BLINK_EN
        blink_phase_d = blink_phase_q;
`endif
        case (state_q)
            IDLE: begin
                led_d = idle_cnt_q;
                if (tick) begin
                    idle_cnt_d = idle_cnt_q + LED_WIDTH'(1);
                end
                if (found) begin
                    state_d    = OWN;
                    grant_d    = win_oh;
                    busy_d     = 1'b1;
                    rr_ptr_d   = rr_next;
                    hold_cnt_d = '0;
                    led_d      = win_data;
`ifdef LED_BLINK_EN
                    blink_phase_d = 1'b0;
`endif
                end
            end
            OWN: begin
                if (!owner_req) begin
                    // Release wins over rotation; arbitration restarts from IDLE.
                    state_d = IDLE;
                    grant_d = '0;
                    busy_d  = 1'b0;
                    led_d   = idle_cnt_q;
`ifdef LED_BLINK_EN
                    blink_phase_d = 1'b0;
`endif
                end else if (hold_full && found && (win_idx != owner_idx)) begin
                    grant_d    = win_oh;
                    rr_ptr_d   = rr_next;
                    hold_cnt_d = '0;
                    led_d      = win_data;
`ifdef LED_BLINK_EN
                    blink_phase_d = 1'b0;
`endif
                end else begin
                    led_d = blank ? '0 : owner_data;
                    if (tick && !hold_full) begin
                        hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                    end
`ifdef LED_BLINK_EN
                    blink_phase_d = blink_phase_q ^ tick;
`endif
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            busy_q     <= 1'b0;
            rr_ptr_q   <= '0;
            idle_cnt_q <= '0;
            hold_cnt_q <= '0;
            led_q      <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            busy_q     <= busy_d;
            rr_ptr_q   <= rr_ptr_d;
            idle_cnt_q <= idle_cnt_d;
            hold_cnt_q <= hold_cnt_d;
            led_q      <= led_d;
        end
    end

`ifdef LED_BLINK_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blink_phase_q <= 1'b0;
        end else begin
            blink_phase_q <= blink_phase_d;
        end
    end
`endif

    assign grant    = grant_q;
    assign busy     = busy_q;
    assign led_data = led_q;

endmodule

// File: tb/tb_led_display_arbiter.sv
// tb/tb_led_display_arbiter.sv - directed-vector bench for led_display_arbiter (TICK_DIV=4, HOLD_TICKS=2)
module tb_led_display_arbiter;

    localparam int LW = 8;
    localparam int NR = 4;

    logic              clk;
    logic              rst;
    logic [NR-1:0]     req;
    logic [NR*LW-1:0]  req_data;
`ifdef LED_BLINK_EN
    logic [NR-1:0]     req_blink;
`endif
    logic [NR-1:0]     grant;
    logic              busy;
    logic [LW-1:0]     led_data;

    int vectors;
    int miscompares;

    led_display_arbiter #(
        .LED_WIDTH  (LW),
        .NUM_REQ    (NR),
        .TICK_DIV   (4),
        .HOLD_TICKS (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .req_data  (req_data),
`ifdef LED_BLINK_EN
        .req_blink (req_blink),
`endif
        .grant     (grant),
        .busy      (busy),
        .led_data  (led_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic set_data(input int idx, input logic [LW-1:0] val);
        req_data[idx*LW +: LW] = val;
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Leaves the bench at a negedge with rst released; the next posedge is edge 1.
    task automatic do_reset();
        @(negedge clk);
        rst      = 1'b1;
        req      = '0;
        req_data = '0;
`ifdef LED_BLINK_EN
        req_blink = '0;
`endif
        #1;
        chk("rst_grant", 32'(grant), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_led", 32'(led_data), 32'h0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        logic [NR-1:0] exp_g;
        logic [LW-1:0] exp_l;
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        req         = '0;
        req_data    = '0;
`ifdef LED_BLINK_EN
        req_blink   = '0;
`endif

        // 1: heartbeat, led after edge e shows floor((e-1)/4)
        do_reset();
        for (int e = 1; e <= 20; e++) begin
            step(1);
            if ((e - 1) % 4 == 0) begin
                chk("idle_led", 32'(led_data), 32'((e - 1) / 4));
                chk("idle_grant", 32'(grant), 32'h0);
            end
        end

        // 2: single requester, one-cycle latency for grant and data
        do_reset();
        req = 4'b0100;
        set_data(2, 8'hA5);
        step(1);
        chk("own_grant", 32'(grant), 32'h4);
        chk("own_busy", 32'(busy), 32'h1);
        chk("own_led", 32'(led_data), 32'hA5);
        set_data(2, 8'h3C);
        step(1);
        chk("own_led_upd", 32'(led_data), 32'h3C);

        // 3: rotation 1 -> 3 -> 1 after two ticks each, no idle gap
        do_reset();
        req = 4'b1010;
        set_data(1, 8'h11);
        set_data(3, 8'h33);
        for (int e = 1; e <= 17; e++) begin
            step(1);
            if (e <= 8 || e >= 17) begin
                exp_g = 4'b0010;
                exp_l = 8'h11;
            end else begin
                exp_g = 4'b1000;
                exp_l = 8'h33;
            end
            chk("rot_grant", 32'(grant), 32'(exp_g));
            chk("rot_led", 32'(led_data), 32'(exp_l));
        end

        // 4: owner release beats pending requester; idle gap shows retained idle_cnt
        do_reset();
        step(8);
        chk("rel_pre_led", 32'(led_data), 32'h1);
        req = 4'b1010;
        set_data(1, 8'h11);
        set_data(3, 8'h33);
        step(1);
        chk("rel_grant1", 32'(grant), 32'h2);
        step(3);
        req = 4'b1000;
        step(1);
        chk("rel_gap_grant", 32'(grant), 32'h0);
        chk("rel_gap_busy", 32'(busy), 32'h0);
        chk("rel_gap_led", 32'(led_data), 32'h2);
        step(1);
        chk("rel_grant3", 32'(grant), 32'h8);
        chk("rel_led3", 32'(led_data), 32'h33);

        // 5: asynchronous reset mid-grant, then re-arbitration from rr_ptr=0
        do_reset();
        req = 4'b0100;
        set_data(0, 8'h5A);
        set_data(2, 8'h77);
        step(1);
        chk("ar_grant_pre", 32'(grant), 32'h4);
        step(2);
        @(posedge clk);
        #3;
        rst = 1'b1;
        req = 4'b0101;
        #1;
        chk("ar_grant", 32'(grant), 32'h0);
        chk("ar_busy", 32'(busy), 32'h0);
        chk("ar_led", 32'(led_data), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        step(1);
        chk("ar_regrant", 32'(grant), 32'h1);
        chk("ar_led_post", 32'(led_data), 32'h5A);

        // 6: blinking owner alternates every 4 cycles; steady without the feature
        do_reset();
        req = 4'b0100;
        set_data(2, 8'hFF);
`ifdef LED_BLINK_EN
        req_blink = 4'b0100;
`endif
        for (int e = 1; e <= 12; e++) begin
            step(1);
            exp_l = 8'hFF;
`ifdef LED_BLINK_EN
            if (((e - 1) / 4) % 2 == 1) begin
                exp_l = 8'h00;
            end
`endif
            chk("blink_led", 32'(led_data), 32'(exp_l));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
